// File: rtl/fir_stream_ctrl.sv
// Sequencing controller for a symmetric FIR: clear, warm-up discard, decimation and credit-limited output buffering.
// Build option FIR_WARMUP_PASS_EN: forward warm-up results (tagged out_warm=1) instead of dropping them.
module fir_stream_ctrl #(
  parameter int DW         = 16,
  parameter int TAPS       = 21,
  parameter int PIPE_LAT   = 4,
  parameter int DECIM      = 1,
  parameter int OBUF_DEPTH = 4
) (
  input  logic          pClk,
  input  logic          pRst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          fir_ce,
  output logic [DW-1:0] fir_din,
  output logic          fir_clr,
  input  logic [DW-1:0] fir_dout,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          out_warm,
  output logic          busy
);

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_WARM  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam int CLR_W  = $clog2(PIPE_LAT + 2);
  localparam int WARM_W = $clog2(TAPS + 1);
  localparam int PTR_W  = $clog2(OBUF_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int CR_W   = $clog2(OBUF_DEPTH + PIPE_LAT + 3) + 1;

`ifdef FIR_WARMUP_PASS_EN
  localparam logic WARM_PASS = 1'b1;
`else
  localparam logic WARM_PASS = 1'b0;
`endif

  logic [1:0]          state_q, state_d;
  logic [CLR_W-1:0]    clr_cnt_q, clr_cnt_d;
  logic [WARM_W-1:0]   warm_cnt_q, warm_cnt_d;
  logic [7:0]          dec_cnt_q, dec_cnt_d;

  logic                fir_ce_q;
  logic [DW-1:0]       fir_din_q;
  logic                ce_keep_q;
  logic [PIPE_LAT-1:0] pipe_ce_q;
  logic [PIPE_LAT-1:0] pipe_keep_q;

  logic [DW-1:0]       buf_mem_q [OBUF_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [CNT_W-1:0]    buf_cnt_q;

  logic                active;
  logic                next_keep;
  logic                credit_ok;
  logic                accept;
  logic                push;
  logic                pop;
  logic [CR_W-1:0]     inflight_kept;

  assign active    = (state_q == ST_WARM) || (state_q == ST_RUN);
  assign next_keep = (state_q == ST_RUN) ? (dec_cnt_q == 8'd0)
                                         : ((state_q == ST_WARM) && WARM_PASS);

  // Every kept sample still travelling toward the buffer holds a slot.
  always_comb begin
    inflight_kept = CR_W'(fir_ce_q & ce_keep_q);
    for (int i = 0; i < PIPE_LAT; i++) begin
      inflight_kept = inflight_kept + CR_W'(pipe_ce_q[i] & pipe_keep_q[i]);
    end
  end

  assign credit_ok = (inflight_kept + CR_W'(buf_cnt_q) + CR_W'(next_keep)) <= CR_W'(OBUF_DEPTH);
  assign in_ready  = active && credit_ok && !flush && !pRst;
  assign accept    = in_valid && in_ready;

  assign push      = pipe_ce_q[PIPE_LAT-1] && pipe_keep_q[PIPE_LAT-1];
  assign out_valid = (buf_cnt_q != '0);
  assign pop       = out_valid && out_ready;

  assign fir_ce    = fir_ce_q;
  assign fir_din   = fir_din_q;
  assign fir_clr   = pRst || (state_q == ST_CLEAR);
  assign out_data  = out_valid ? buf_mem_q[rd_ptr_q] : '0;
  assign busy      = (state_q != ST_RUN) || fir_ce_q || (|pipe_ce_q) || out_valid;

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    warm_cnt_d = warm_cnt_q;
    dec_cnt_d  = dec_cnt_q;
    if (flush) begin
      state_d    = ST_CLEAR;
      clr_cnt_d  = '0;
      warm_cnt_d = '0;
      dec_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (clr_cnt_q == CLR_W'(PIPE_LAT)) begin
            state_d   = ST_WARM;
            clr_cnt_d = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
          end
        end
        ST_WARM: begin
          if (accept) begin
            if (warm_cnt_q == WARM_W'(TAPS - 2)) begin
              state_d    = ST_RUN;
              warm_cnt_d = '0;
            end else begin
              warm_cnt_d = warm_cnt_q + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            dec_cnt_d = (dec_cnt_q == 8'(DECIM - 1)) ? 8'd0 : dec_cnt_q + 8'd1;
          end
        end
        default: state_d = ST_CLEAR;
      endcase
    end
  end

  always_ff @(posedge pClk) begin
    if (pRst) begin
      state_q    <= ST_CLEAR;
      clr_cnt_q  <= '0;
      warm_cnt_q <= '0;
      dec_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      warm_cnt_q <= warm_cnt_d;
      dec_cnt_q  <= dec_cnt_d;
    end
  end

  always_ff @(posedge pClk) begin
    if (pRst) begin
      fir_din_q <= '0;
    end else if (accept) begin
      fir_din_q <= in_data;
    end
  end

  // The ce stage plus PIPE_LAT tag stages line up with the filter's result latency.
  always_ff @(posedge pClk) begin
    if (pRst || flush) begin
      fir_ce_q    <= 1'b0;
      ce_keep_q   <= 1'b0;
      pipe_ce_q   <= '0;
      pipe_keep_q <= '0;
    end else begin
      fir_ce_q       <= accept;
      ce_keep_q      <= accept && next_keep;
      pipe_ce_q[0]   <= fir_ce_q;
      pipe_keep_q[0] <= ce_keep_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pipe_ce_q[i]   <= pipe_ce_q[i-1];
        pipe_keep_q[i] <= pipe_keep_q[i-1];
      end
    end
  end

  always_ff @(posedge pClk) begin
    if (push) begin
      buf_mem_q[wr_ptr_q] <= fir_dout;
    end
  end

  always_ff @(posedge pClk) begin
    if (pRst || flush) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      buf_cnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      buf_cnt_q <= buf_cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

`ifdef FIR_WARMUP_PASS_EN
  logic                ce_warm_q;
  logic [PIPE_LAT-1:0] pipe_warm_q;
  logic                buf_warm_q [OBUF_DEPTH];

  always_ff @(posedge pClk) begin
    if (pRst || flush) begin
      ce_warm_q   <= 1'b0;
      pipe_warm_q <= '0;
    end else begin
      ce_warm_q      <= accept && (state_q == ST_WARM);
      pipe_warm_q[0] <= ce_warm_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pipe_warm_q[i] <= pipe_warm_q[i-1];
      end
    end
  end

  always_ff @(posedge pClk) begin
    if (push) begin
      buf_warm_q[wr_ptr_q] <= pipe_warm_q[PIPE_LAT-1];
    end
  end

  assign out_warm = out_valid && buf_warm_q[rd_ptr_q];
`else
  assign out_warm = 1'b0;
`endif

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Randomized bench for fir_stream_ctrl: a stub FIR supplies results and a sample-history model predicts the output stream.
module tb_fir_stream_ctrl;

  localparam int DW         = 16;
  localparam int TAPS       = 21;
  localparam int PIPE_LAT   = 4;
  localparam int DECIM      = 4;
  localparam int OBUF_DEPTH = 4;

`ifdef FIR_WARMUP_PASS_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic          clk;
  logic          pRst;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          fir_ce;
  logic [DW-1:0] fir_din;
  logic          fir_clr;
  logic [DW-1:0] fir_dout;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          out_warm;
  logic          busy;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  fir_stream_ctrl #(
    .DW(DW), .TAPS(TAPS), .PIPE_LAT(PIPE_LAT), .DECIM(DECIM), .OBUF_DEPTH(OBUF_DEPTH)
  ) dut (
    .pClk(clk), .pRst(pRst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .fir_ce(fir_ce), .fir_din(fir_din), .fir_clr(fir_clr), .fir_dout(fir_dout),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_warm(out_warm), .busy(busy)
  );

  function automatic int coef(input int k);
    return ((k < TAPS - 1 - k) ? k : TAPS - 1 - k) + 1;
  endfunction

  // Stub filter: delay line advances on fir_ce, result appears PIPE_LAT cycles later, junk otherwise.
  logic [DW-1:0] dl [TAPS-1];
  logic [DW-1:0] st [PIPE_LAT];

  function automatic logic [DW-1:0] stub_y(input logic [DW-1:0] x0);
    logic [DW-1:0] acc;
    acc = DW'(coef(0) * int'(x0));
    for (int k = 1; k < TAPS; k++) acc = acc + DW'(coef(k) * int'(dl[k-1]));
    return acc;
  endfunction

  always @(posedge clk) begin
    if (fir_clr) begin
      for (int k = 0; k < TAPS - 1; k++) dl[k] <= '0;
      for (int k = 0; k < PIPE_LAT; k++) st[k] <= '0;
    end else begin
      if (fir_ce) begin
        dl[0] <= fir_din;
        for (int k = 1; k < TAPS - 1; k++) dl[k] <= dl[k-1];
      end
      st[0] <= fir_ce ? stub_y(fir_din) : DW'($urandom);
      for (int k = 1; k < PIPE_LAT; k++) st[k] <= st[k-1];
    end
  end

  assign fir_dout = st[PIPE_LAT-1];

  // Reference model: sample history since the last clear and the queue of expected outputs.
  logic [DW:0]   exp_q [$];
  logic [DW-1:0] hist [$];
  int            n_acc;
  int            n_pop;
  int            n_checks;
  int            n_errors;
  logic          prev_acc;
  logic [DW-1:0] prev_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    exp_q.delete();
    n_acc = 0;
  endtask

  task automatic model_accept(input logic [DW-1:0] x);
    logic [DW-1:0] y;
    hist.push_back(x);
    if (hist.size() > TAPS) void'(hist.pop_front());
    n_acc++;
    y = '0;
    for (int k = 0; k < hist.size(); k++) y = y + DW'(coef(k) * int'(hist[hist.size() - 1 - k]));
    if (n_acc >= TAPS) begin
      if ((n_acc - TAPS) % DECIM == 0) exp_q.push_back({1'b0, y});
    end else if (WP) begin
      exp_q.push_back({1'b1, y});
    end
  endtask

  task automatic cyc(input logic rst, input logic v, input logic fl, input logic ordy);
    logic [DW:0] e;
    @(negedge clk);
    pRst      = rst;
    in_valid  = v;
    in_data   = DW'($urandom);
    flush     = fl;
    out_ready = ordy;
    #1;
    if (!rst) begin
      check("fir_ce", 32'(fir_ce), 32'(prev_acc));
      if (prev_acc) check("fir_din", 32'(fir_din), 32'(prev_data));
      if (!WP && n_acc < TAPS) check("early_out_valid", 32'(out_valid), 0);
      if (out_valid && out_ready) begin
        check("pop_avail", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e[DW-1:0]));
          check("out_warm", 32'(out_warm), 32'(e[DW]));
          n_pop++;
          $display("out %0d: data=%04h warm=%0b t=%0t", n_pop, out_data, out_warm, $time);
        end
      end
      prev_acc  = in_valid && in_ready;
      prev_data = in_data;
      if (fl) model_clear();
      if (prev_acc) model_accept(in_data);
    end else begin
      prev_acc = 1'b0;
      model_clear();
    end
  endtask

  task automatic run_clear(input string tag);
    int len;
    len = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      if (!fir_clr) break;
      len++;
      check("clear_busy", 32'(busy), 1);
      check("clear_out_valid", 32'(out_valid), 0);
      check("clear_in_ready", 32'(in_ready), 0);
    end
    check(tag, 32'(len), 32'(PIPE_LAT + 1));
  endtask

  task automatic reset_checks();
    check("rst_fir_clr", 32'(fir_clr), 1);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_fir_ce", 32'(fir_ce), 0);
    check("rst_fir_din", 32'(fir_din), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_warm", 32'(out_warm), 0);
  endtask

  initial begin
    pRst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = '0; out_ready = 1'b1;
    prev_acc = 1'b0; prev_data = '0;
    n_acc = 0; n_pop = 0; n_checks = 0; n_errors = 0;

    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      reset_checks();
    end

    // Warm-up then 100 post-warm-up samples with decimation.
    n_pop = 0;
    run_clear("clear_len_reset");
    for (int i = 0; i < 3000 && !(n_acc >= 120 && exp_q.size() == 0); i++) begin
      cyc(1'b0, n_acc < 120, 1'b0, 1'b1);
    end
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("decim_pending", 32'(exp_q.size()), 0);
    check("decim_count", 32'(n_pop), 32'(25 + (WP ? 20 : 0)));

    // Back-pressure: buffer fills to OBUF_DEPTH, intake stalls, nothing lost.
    for (int i = 0; i < 50; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("bp_in_ready", 32'(in_ready), 0);
    check("bp_fir_ce", 32'(fir_ce), 0);
    check("bp_out_valid", 32'(out_valid), 1);
    check("bp_pending", 32'(exp_q.size()), 32'(OBUF_DEPTH));
    n_pop = 0;
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("bp_drain", 32'(n_pop), 32'(OBUF_DEPTH));

    // Flush with results buffered and in flight, colliding with a valid sample.
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check("flush_in_ready", 32'(in_ready), 0);
    run_clear("clear_len_flush");
    for (int i = 0; i < 60; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);

    // Random traffic with occasional flush and a mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500 || i == 1501) begin
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        if (i == 1501) reset_checks();
      end else begin
        cyc(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0);
      end
    end

    for (int i = 0; i < 300; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 200 && (exp_q.size() != 0 || out_valid); i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("final_pending", 32'(exp_q.size()), 0);
    check("final_out_valid", 32'(out_valid), 0);
    check("final_busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
